sprite_blitter: RTL and testbench

- Drawing stage that copies one 32x32 sprite from the read-only sprite buffer into the back frame buffer at a signed screen position.
- Sits upstream of the double-buffered VRAM. Its write port is steered by the top level to whichever VRAM is currently the write target.
- Supports a transparent palette index, horizontal flip, and clipping at all four screen edges.
- Runs one start/busy/done transaction per sprite, so a sequencer can draw several sprites per frame after the background pass.

---
 rtl/sprite_blitter_if.sv | 32 +++
 rtl/sprite_blitter.sv | 170 +++++++++++++++++
 tb/tb_sprite_blitter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// Bus bundle for the sprite blitter: start/busy/done control, sprite read port
// and frame buffer write port. The blitter uses the slave view, the sequencer
// and memories the master view.
interface sprite_blitter_if #(
  parameter int SPR_IDX_W   = 3,
  parameter int SPR_A_WIDTH = 13,
  parameter int FB_A_WIDTH  = 16,
  parameter int D_WIDTH     = 8
);
  logic                   i_start;
  logic [SPR_IDX_W-1:0]   i_sprite_idx;
  logic signed [10:0]     i_x;
  logic signed [9:0]      i_y;
  logic                   i_flip_x;
  logic                   o_busy;
  logic                   o_done;
  logic [SPR_A_WIDTH-1:0] o_spr_addr;
  logic [D_WIDTH-1:0]     i_spr_data;
  logic [FB_A_WIDTH-1:0]  o_fb_addr;
  logic [D_WIDTH-1:0]     o_fb_data;
  logic                   o_fb_we;

  modport slave (
    input  i_start, i_sprite_idx, i_x, i_y, i_flip_x, i_spr_data,
    output o_busy, o_done, o_spr_addr, o_fb_addr, o_fb_data, o_fb_we
  );

  modport master (
    output i_start, i_sprite_idx, i_x, i_y, i_flip_x, i_spr_data,
    input  o_busy, o_done, o_spr_addr, o_fb_addr, o_fb_data, o_fb_we
  );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies one SPRITE_SIZE x SPRITE_SIZE sprite into the frame
// buffer at a signed screen position, skipping transparent pixels, optionally
// mirrored horizontally, clipped (never wrapped) at all four screen edges.
// Fixed cost of SPRITE_SIZE^2 + 3 cycles per blit regardless of clipping.
module sprite_blitter #(
  parameter int SCREEN_WIDTH    = 320,
  parameter int SCREEN_HEIGHT   = 180,
  parameter int SPRITE_SIZE     = 32,
  parameter int SPR_IDX_W       = 3,
  parameter int SPR_A_WIDTH     = 13,
  parameter int FB_A_WIDTH      = 16,
  parameter int D_WIDTH         = 8,
  parameter int TRANSPARENT_IDX = 0
) (
  input logic             CLK,
  input logic             rst,
  sprite_blitter_if.slave bus
);
  localparam int SS_W = $clog2(SPRITE_SIZE);
  localparam logic [SS_W-1:0]   LAST_PX  = SS_W'(SPRITE_SIZE - 1);
  localparam logic signed [10:0] SCR_W_S = 11'(SCREEN_WIDTH);
  localparam logic signed [9:0]  SCR_H_S = 10'(SCREEN_HEIGHT);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                 state_q;
  logic                   drain_q;
  logic                   busy_q;
  logic                   done_q;
  logic [SS_W-1:0]        px_q, py_q;
  logic [SS_W-1:0]        px_d, py_d;
  logic                   last_px;
  logic [SPR_IDX_W-1:0]   idx_q;
  logic signed [10:0]     x_q;
  logic signed [9:0]      y_q;
  logic                   flip_q;
  logic [SPR_A_WIDTH-1:0] spr_addr_q;

  logic signed [10:0]     scr_x;
  logic signed [9:0]      scr_y;
  logic                   vld_p1;
  logic                   vis_p1;
  logic [FB_A_WIDTH-1:0]  fb_addr_p1;
  logic                   wr_en;
  logic                   we_p2;
  logic [FB_A_WIDTH-1:0]  fb_addr_p2;
  logic [D_WIDTH-1:0]     fb_data_p2;

  // Sprite buffer address; the mirrored column is the bitwise inverse because
  // SPRITE_SIZE is a power of two.
  function automatic logic [SPR_A_WIDTH-1:0] spr_offset(
    input logic [SPR_IDX_W-1:0] idx,
    input logic [SS_W-1:0]      row,
    input logic [SS_W-1:0]      col,
    input logic                 flip
  );
    logic [SS_W-1:0] src;
    src = flip ? ~col : col;
    return SPR_A_WIDTH'({idx, row, src});
  endfunction

  // Clip test on the signed screen coordinate; negatives are rejected, not wrapped.
  function automatic logic on_screen(input logic signed [10:0] sx,
                                     input logic signed [9:0]  sy);
    return (sx >= 11'sd0) && (sx < SCR_W_S) && (sy >= 10'sd0) && (sy < SCR_H_S);
  endfunction

  // Linear frame buffer offset; only meaningful when on_screen() holds.
  function automatic logic [FB_A_WIDTH-1:0] fb_offset(input logic signed [10:0] sx,
                                                      input logic signed [9:0]  sy);
    logic [FB_A_WIDTH-1:0] ux, uy;
    ux = FB_A_WIDTH'($unsigned(sx));
    uy = FB_A_WIDTH'($unsigned(sy));
    return uy * FB_A_WIDTH'(SCREEN_WIDTH) + ux;
  endfunction

  assign scr_x = x_q + 11'(px_q);
  assign scr_y = y_q + 10'(py_q);

  // Raster-order successor of the pixel whose address is currently presented.
  always_comb begin
    last_px = (px_q == LAST_PX) && (py_q == LAST_PX);
    px_d    = px_q + SS_W'(1);
    py_d    = (px_q == LAST_PX) ? py_q + SS_W'(1) : py_q;
  end

  // Control FSM: accept start, walk the sprite in raster order, drain the
  // two-stage write pipeline, then pulse done.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= IDLE;
      drain_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      spr_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            idx_q      <= bus.i_sprite_idx;
            x_q        <= bus.i_x;
            y_q        <= bus.i_y;
            flip_q     <= bus.i_flip_x;
            px_q       <= '0;
            py_q       <= '0;
            spr_addr_q <= spr_offset(bus.i_sprite_idx, '0, '0, bus.i_flip_x);
            busy_q     <= 1'b1;
            state_q    <= READ;
          end
        end
        READ: begin
          if (last_px) begin
            drain_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            px_q       <= px_d;
            py_q       <= py_d;
            spr_addr_q <= spr_offset(idx_q, py_d, px_d, flip_q);
          end
        end
        DRAIN: begin
          if (drain_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            drain_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage 1: screen position and visibility of the pixel whose read is in flight.
  always_ff @(posedge CLK) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= (state_q == READ);
    vis_p1     <= on_screen(scr_x, scr_y);
    fb_addr_p1 <= fb_offset(scr_x, scr_y);
  end

  assign wr_en = vld_p1 && vis_p1 && (bus.i_spr_data != D_WIDTH'(TRANSPARENT_IDX));

  // Stage 2: frame buffer write; address and data hold between writes.
  always_ff @(posedge CLK) begin
    if (rst) begin
      we_p2      <= 1'b0;
      fb_addr_p2 <= '0;
      fb_data_p2 <= '0;
    end else begin
      we_p2 <= wr_en;
      if (wr_en) begin
        fb_addr_p2 <= fb_addr_p1;
        fb_data_p2 <= bus.i_spr_data;
      end
    end
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_spr_addr = spr_addr_q;
  assign bus.o_fb_we    = we_p2;
  assign bus.o_fb_addr  = fb_addr_p2;
  assign bus.o_fb_data  = fb_data_p2;
endmodule

// File: tb/tb_sprite_blitter.sv
// Testbench for sprite_blitter: sprite ROM model, per-cycle reference model of
// the expected read addresses and frame buffer writes, plus literal checks.
`timescale 1ns/1ps
module tb_sprite_blitter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprite_blitter_if bus ();
  sprite_blitter dut (.CLK(clk), .rst(rst), .bus(bus));

  // Sprite buffer: synchronous read, data one cycle after the address.
  logic [7:0] spr_mem [0:8191];
  always @(posedge clk) bus.i_spr_data <= spr_mem[bus.o_spr_addr];

  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  string tag = "init";

  bit exp_we   [0:1031];
  int exp_addr [0:1031];
  int exp_data [0:1031];
  int exp_spr  [0:1031];
  int m_addr = 0;
  int m_data = 0;

  int wr_cnt, first_cyc, first_addr, first_data, last_addr, min_addr, max_addr;
  int addr0_data, done_cnt, done_cyc;
  bit odd5_ok;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [%s cycle %0d]: got %0d, expected %0d", name, tag, cyc, act, exp);
    end
  endtask

  // Expected behaviour of one blit, straight from the pixel rules.
  task automatic build_model(input int idx, input int x, input int y, input bit flip);
    for (int c = 0; c < 1032; c++) begin
      exp_we[c] = 1'b0; exp_addr[c] = 0; exp_data[c] = 0; exp_spr[c] = 0;
    end
    for (int n = 0; n < 1024; n++) begin
      int row, col, src, sx, sy, d;
      row = n / 32;
      col = n % 32;
      src = flip ? 31 - col : col;
      exp_spr[n+1] = idx * 1024 + row * 32 + src;
      d  = int'(spr_mem[exp_spr[n+1]]);
      sx = x + col;
      sy = y + row;
      if (sx >= 0 && sx < 320 && sy >= 0 && sy < 180 && d != 0) begin
        exp_we[n+3]   = 1'b1;
        exp_addr[n+3] = sy * 320 + sx;
        exp_data[n+3] = d;
      end
    end
  endtask

  task automatic clear_stats();
    wr_cnt = 0; first_cyc = -1; first_addr = -1; first_data = -1; last_addr = -1;
    min_addr = 1 << 30; max_addr = -1; addr0_data = -1; done_cnt = 0; done_cyc = -1;
    odd5_ok = 1'b1;
  endtask

  // Compare all outputs against the model for cycle c (sampled at the negedge).
  task automatic compare_cycle(input int c, input int odd_x);
    int a, d;
    cyc = c;
    chk("busy",  int'(bus.o_busy),  int'(c >= 1 && c <= 1026));
    chk("done",  int'(bus.o_done),  int'(c == 1027));
    chk("fb_we", int'(bus.o_fb_we), int'(exp_we[c]));
    if (exp_we[c]) begin
      m_addr = exp_addr[c];
      m_data = exp_data[c];
    end
    chk("fb_addr", int'(bus.o_fb_addr), m_addr);
    chk("fb_data", int'(bus.o_fb_data), m_data);
    if (c >= 1 && c <= 1024) chk("spr_addr", int'(bus.o_spr_addr), exp_spr[c]);
    if (bus.o_done) begin
      done_cnt++;
      done_cyc = c;
    end
    if (bus.o_fb_we) begin
      a = int'(bus.o_fb_addr);
      d = int'(bus.o_fb_data);
      wr_cnt++;
      if (first_cyc < 0) begin
        first_cyc = c; first_addr = a; first_data = d;
      end
      last_addr = a;
      if (a < min_addr) min_addr = a;
      if (a > max_addr) max_addr = a;
      if (a == 0) addr0_data = d;
      if (d != 5 || (((a % 320) - odd_x) % 2) == 0) odd5_ok = 1'b0;
    end
  endtask

  task automatic start_blit(input int idx, input int x, input int y, input bit flip);
    build_model(idx, x, y, flip);
    clear_stats();
    @(negedge clk);
    bus.i_sprite_idx = 3'(idx);
    bus.i_x          = 11'(x);
    bus.i_y          = 10'(y);
    bus.i_flip_x     = flip;
    bus.i_start      = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
  endtask

  // Full blit; optional start pulses at cycles poke_a / poke_b with other x/y.
  task automatic run_blit(input string name, input int idx, input int x, input int y,
                          input bit flip, input int poke_a, input int poke_b);
    tag = name;
    start_blit(idx, x, y, flip);
    for (int c = 1; c <= 1030; c++) begin
      @(negedge clk);
      compare_cycle(c, x);
      if (c == poke_a || c == poke_b) begin
        bus.i_x     = 11'(5);
        bus.i_y     = 10'(7);
        bus.i_start = 1'b1;
      end else begin
        bus.i_start = 1'b0;
      end
    end
    bus.i_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) spr_mem[i] = 8'h00;
    for (int n = 0; n < 1024; n++) begin
      int row, col;
      row = n / 32;
      col = n % 32;
      // sprite 0: row*32+col folded into 1..255 so only pixel (0,0) is transparent
      spr_mem[n]          = (n == 0) ? 8'd0 : 8'(((n - 1) % 255) + 1);
      spr_mem[1024 + n]   = 8'(((row * 7 + col * 3) % 254) + 1);
      spr_mem[2048 + n]   = 8'(col + 1 + ((row & 3) << 6));
      spr_mem[7168 + n]   = (col % 2 == 1) ? 8'd5 : 8'd0;
    end

    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_sprite_idx = '0; bus.i_x = '0; bus.i_y = '0; bus.i_flip_x = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tag = "reset"; cyc = 0;
    chk("rst_busy",     int'(bus.o_busy),     0);
    chk("rst_done",     int'(bus.o_done),     0);
    chk("rst_fb_we",    int'(bus.o_fb_we),    0);
    chk("rst_spr_addr", int'(bus.o_spr_addr), 0);
    chk("rst_fb_addr",  int'(bus.o_fb_addr),  0);
    chk("rst_fb_data",  int'(bus.o_fb_data),  0);

    // Centred blit with a start pulse while busy and another in the DONE cycle.
    run_blit("centred", 0, 144, 148, 1'b0, 100, 1027);
    chk("centred_writes",     wr_cnt,     1023);
    chk("centred_first_cyc",  first_cyc,  4);
    chk("centred_first_addr", first_addr, 148 * 320 + 145);
    chk("centred_first_data", first_data, 1);
    chk("centred_done_cnt",   done_cnt,   1);
    chk("centred_done_cyc",   done_cyc,   1027);

    run_blit("transparent", 7, 100, 50, 1'b0, -1, -1);
    chk("transp_writes",  wr_cnt,       512);
    chk("transp_odd5",    int'(odd5_ok), 1);

    run_blit("clip_tl", 1, -8, -4, 1'b0, -1, -1);
    chk("tl_writes",   wr_cnt,   672);
    chk("tl_min_addr", min_addr, 0);
    chk("tl_max_in_range", int'(max_addr < 57600), 1);

    run_blit("clip_br", 1, 300, 170, 1'b0, -1, -1);
    chk("br_writes",    wr_cnt,    200);
    chk("br_last_addr", last_addr, 57599);
    chk("br_max_in_range", int'(max_addr < 57600), 1);

    run_blit("offscreen", 1, -40, 20, 1'b0, -1, -1);
    chk("off_writes",   wr_cnt,   0);
    chk("off_done_cyc", done_cyc, 1027);

    run_blit("flip", 2, 0, 0, 1'b1, -1, -1);
    chk("flip_addr0_data", addr0_data, 32);

    // Reset at cycle 500 of a blit, then reset together with start.
    tag = "rst_mid";
    start_blit(0, 144, 148, 1'b0);
    for (int c = 1; c <= 500; c++) begin
      @(negedge clk);
      compare_cycle(c, 0);
    end
    chk("mid_we_before", int'(bus.o_fb_we), 1);
    rst = 1'b1;
    @(negedge clk);
    cyc = 501;
    chk("mid_busy", int'(bus.o_busy),  0);
    chk("mid_we",   int'(bus.o_fb_we), 0);
    chk("mid_done", int'(bus.o_done),  0);
    m_addr = 0; m_data = 0;
    bus.i_start = 1'b1;
    @(negedge clk);
    cyc = 502;
    chk("rst_start_busy", int'(bus.o_busy), 0);
    rst = 1'b0;
    bus.i_start = 1'b0;
    for (int c = 503; c < 1100; c++) begin
      @(negedge clk);
      cyc = c;
      chk("post_rst_busy", int'(bus.o_busy),  0);
      chk("post_rst_done", int'(bus.o_done),  0);
      chk("post_rst_we",   int'(bus.o_fb_we), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
